mux8way_rr_arbiter: RTL

//   Collects words from 8 source channels onto one output channel: the gathering counterpart of the
//   1-to-8 distribution path. Each channel uses a valid/ready handshake. Round-robin arbitration picks
//   one channel per cycle into a single registered output stage. The output also carries a channel

---
 rtl/mux8way_rr_arbiter.sv | 63 ++++++
 1 files changed

// File: rtl/mux8way_rr_arbiter.sv
// 8-to-1 valid/ready gather with round-robin arbitration.
// One registered output stage tagged with the source channel index.
module mux8way_rr_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         in_valid,
  input  logic [8*WIDTH-1:0] in_data,
  output logic [7:0]         in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [2:0]         out_sel,
  input  logic               out_ready
);

  logic [2:0] ptr;
  logic [2:0] grant;
  logic       found;
  logic       load_en;
  logic [2:0] idx;

  assign load_en = !out_valid || out_ready;

  // Search starts at ptr so the last winner goes to the back of the line.
  always_comb begin
    found = 1'b0;
    grant = 3'd0;
    idx   = 3'd0;
    for (int k = 0; k < 8; k++) begin
      idx = ptr + 3'(k);
      if (!found && in_valid[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  always_comb begin
    in_ready = 8'h00;
    if (!reset && load_en && found)
      in_ready = 8'h01 << grant;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= 3'd0;
      ptr       <= 3'd0;
    end else if (load_en) begin
      if (found) begin
        out_valid <= 1'b1;
        out_data  <= in_data[int'(grant)*WIDTH +: WIDTH];
        out_sel   <= grant;
        ptr       <= grant + 3'd1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
